mod10_counter: RTL and testbench

A decimal (modulo-10) counter with a 3-bit operation code and a thermometer-coded output. It sits in the display/indicator datapath. The count state holds 0–9 and updates once per clock under `ctrl` command. The value is presented as a 16-bit thermometer bar for LED-style readout.

---
 rtl/mod10_pkg.sv | 20 ++
 rtl/thermo_encoder.sv | 16 +
 rtl/mod10_counter.sv | 51 +++++
 tb/tb_mod10_counter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mod10_pkg.sv
// Shared constants for the decimal counter: ctrl opcodes, modulus and bar width.
package mod10_pkg;

  localparam logic [2:0] OP_HOLD    = 3'd0;
  localparam logic [2:0] OP_UP      = 3'd1;
  localparam logic [2:0] OP_DOWN    = 3'd2;
  localparam logic [2:0] OP_LOAD    = 3'd3;
  localparam logic [2:0] OP_CLEAR   = 3'd4;
  localparam logic [2:0] OP_SET_MAX = 3'd5;

  localparam logic [3:0] MOD_VALUE = 4'd10;
  localparam logic [3:0] MAX_COUNT = MOD_VALUE - 4'd1;
  localparam int         THERMO_W  = 16;

  // Folds an out-of-range load value back into 0..9 by subtracting the modulus.
  function automatic logic [3:0] fold_load(input logic [3:0] value);
    return (value > MAX_COUNT) ? value - MOD_VALUE : value;
  endfunction

endpackage

// File: rtl/thermo_encoder.sv
// Purely combinational binary-to-thermometer encoder: bit i is set when i < value.
module thermo_encoder
  import mod10_pkg::*;
(
  input  logic [3:0]          value,
  output logic [THERMO_W-1:0] thermo
);

  always_comb begin
    thermo = '0;
    for (int i = 0; i < THERMO_W; i++) begin
      thermo[i] = (4'(i) < value);
    end
  end

endmodule

// File: rtl/mod10_counter.sv
// Modulo-10 counter driven by a 3-bit opcode, shown as a 16-bit thermometer bar.
// Define MOD10_LOAD_CLAMP_EN to saturate out-of-range loads to 9 instead of folding them.
module mod10_counter
  import mod10_pkg::*;
(
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [2:0]          ctrl,
  input  logic [3:0]          inp,
  output logic [THERMO_W-1:0] thermo_count
);

  logic [3:0] count;
  logic [3:0] next_count;
  logic [3:0] load_value;

`ifdef MOD10_LOAD_CLAMP_EN
  assign load_value = (inp > MAX_COUNT) ? MAX_COUNT : inp;
`else
  assign load_value = fold_load(inp);
`endif

  // Reserved and unknown opcodes fall through to default so they act as HOLD.
  always_comb begin
    next_count = count;
    case (ctrl)
      OP_HOLD:    next_count = count;
      OP_UP:      next_count = (count >= MAX_COUNT) ? 4'd0 : count + 4'd1;
      OP_DOWN:    next_count = (count == 4'd0 || count > MAX_COUNT) ? MAX_COUNT : count - 4'd1;
      OP_LOAD:    next_count = load_value;
      OP_CLEAR:   next_count = 4'd0;
      OP_SET_MAX: next_count = MAX_COUNT;
      default:    next_count = count;
    endcase
  end

  // rst_n keeps its legacy name but is an active-high synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (rst_n) begin
      count <= 4'd0;
    end else begin
      count <= next_count;
    end
  end

  thermo_encoder u_thermo_encoder (
    .value  (count),
    .thermo (thermo_count)
  );

endmodule

// File: tb/tb_mod10_counter.sv
// Scoreboard bench for mod10_counter: a reference model queues the expected bar per edge.
module tb_mod10_counter;

  logic        sys_clk;
  logic        rst_n;
  logic [2:0]  ctrl;
  logic [3:0]  inp;
  logic [15:0] thermo_count;

  int total_checks;
  int bad_checks;
  int model_count;
  logic [15:0] expected_q[$];

  mod10_counter dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .ctrl         (ctrl),
    .inp          (inp),
    .thermo_count (thermo_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic int model_next(input int c, input logic r, input logic [2:0] op,
                                    input logic [3:0] v);
    if (r) return 0;
    case (op)
      3'd1: return (c == 9) ? 0 : c + 1;
      3'd2: return (c == 0) ? 9 : c - 1;
      3'd3: begin
`ifdef MOD10_LOAD_CLAMP_EN
        return (int'(v) > 9) ? 9 : int'(v);
`else
        return (int'(v) > 9) ? int'(v) - 10 : int'(v);
`endif
      end
      3'd4: return 0;
      3'd5: return 9;
      default: return c;
    endcase
  endfunction

  function automatic logic [15:0] model_thermo(input int c);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < c; i++) t[i] = 1'b1;
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one edge's worth of inputs, queue the model's result, then check after the edge.
  task automatic applyStimulus(input string tag, input logic r, input logic [2:0] op,
                               input logic [3:0] v);
    logic [15:0] exp;
    @(negedge sys_clk);
    rst_n = r;
    ctrl  = op;
    inp   = v;
    model_count = model_next(model_count, r, op, v);
    expected_q.push_back(model_thermo(model_count));
    @(posedge sys_clk);
    #1;
    if (expected_q.size() == 0) begin
      checkOutput({tag, "_empty_queue"}, thermo_count, 16'hxxxx);
    end else begin
      exp = expected_q.pop_front();
      checkOutput(tag, thermo_count, exp);
    end
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    model_count  = 0;
    rst_n = 1'b1;
    ctrl  = 3'd1;
    inp   = 4'd0;

    applyStimulus("reset0", 1'b1, 3'd1, 4'd0);
    applyStimulus("reset1", 1'b1, 3'd1, 4'd0);
    checkOutput("reset_const", thermo_count, 16'h0000);
    applyStimulus("up_after_reset", 1'b0, 3'd1, 4'd0);
    checkOutput("up_after_reset_const", thermo_count, 16'h0001);

    applyStimulus("load8", 1'b0, 3'd3, 4'd8);
    checkOutput("load8_const", thermo_count, 16'h00FF);
    for (int i = 0; i < 3; i++) applyStimulus("hold", 1'b0, 3'd0, 4'd3);
    checkOutput("hold_const", thermo_count, 16'h00FF);

    applyStimulus("up_to_9", 1'b0, 3'd1, 4'd0);
    checkOutput("up_to_9_const", thermo_count, 16'h01FF);
    applyStimulus("wrap_up", 1'b0, 3'd1, 4'd0);
    checkOutput("wrap_up_const", thermo_count, 16'h0000);
    applyStimulus("wrap_down", 1'b0, 3'd2, 4'd0);
    checkOutput("wrap_down_const", thermo_count, 16'h01FF);

    applyStimulus("clear", 1'b0, 3'd4, 4'd0);
    applyStimulus("set_max", 1'b0, 3'd5, 4'd0);
    checkOutput("set_max_const", thermo_count, 16'h01FF);
    applyStimulus("clear2", 1'b0, 3'd4, 4'd0);
    checkOutput("clear_const", thermo_count, 16'h0000);
    applyStimulus("down_from_0", 1'b0, 3'd2, 4'd0);
    applyStimulus("down_8", 1'b0, 3'd2, 4'd0);
    applyStimulus("rsv6", 1'b0, 3'd6, 4'd1);
    applyStimulus("rsv7", 1'b0, 3'd7, 4'd2);
    checkOutput("reserved_const", thermo_count, 16'h00FF);
    applyStimulus("ctrl_x", 1'b0, 3'bxxx, 4'd4);

    applyStimulus("load12", 1'b0, 3'd3, 4'd12);
`ifdef MOD10_LOAD_CLAMP_EN
    checkOutput("load12_const", thermo_count, 16'h01FF);
`else
    checkOutput("load12_const", thermo_count, 16'h0003);
`endif
    applyStimulus("load15", 1'b0, 3'd3, 4'd15);
    applyStimulus("load10", 1'b0, 3'd3, 4'd10);
    applyStimulus("load9", 1'b0, 3'd3, 4'd9);

    applyStimulus("reset_prio", 1'b1, 3'd3, 4'd7);
    checkOutput("reset_prio_const", thermo_count, 16'h0000);

    for (int i = 0; i < 80; i++) begin
      applyStimulus("random", ($urandom_range(15) == 0), 3'($urandom_range(7)),
                    4'($urandom_range(15)));
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
